// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
// Shared CPU constants and types for the write-back register file and the
// pipeline stage registers that feed it.
//   DATA_W : register and datapath width
//   NREG   : number of architectural registers
//   IDX_W  : register index width (log2 of NREG)
//   CNT_W  : width of the committed-write counter
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 16;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 16;

  typedef logic [IDX_W-1:0] reg_idx_t;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_array.sv
// -----------------------------------------------------------------------------
// regfile_array
// Storage for the architectural registers: one synchronous write port and
// three combinational read ports (two operand ports plus a debug port).
// Ports:
//   clk, rst            : clock and synchronous active-high reset (clears all)
//   we, waddr, wdata    : write port, applied on posedge clk when rst is low
//   raddr_a / rdata_a   : operand read port A
//   raddr_b / rdata_b   : operand read port B
//   raddr_d / rdata_d   : debug read port
// -----------------------------------------------------------------------------
module regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int NREG   = wb_regfile_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr_a,
  input  logic [IDX_W-1:0]  raddr_b,
  input  logic [IDX_W-1:0]  raddr_d,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_d
);

  logic [DATA_W-1:0] mem_r [NREG];

  // Register storage: reset clears every entry and discards a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational read ports straight from storage.
  always_comb begin
    rdata_a = mem_r[raddr_a];
    rdata_b = mem_r[raddr_b];
    rdata_d = mem_r[raddr_d];
  end

endmodule : regfile_array

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Write-back stage register file. Selects the write-back value (load data or
// ALU result), commits it to the register array, and bypasses it to the
// decode-stage read ports so decode sees the value written at the next edge.
// Ports:
//   Clk, Rst            : clock and synchronous active-high reset
//   RegWrite3           : write-back enable from MEM/WB
//   MemotoReg3          : 1 = write DataOut3, 0 = write Result3
//   DataOut3, Result3   : load data and ALU result candidates
//   RegWriteIndex3      : destination register index
//   ReadIndexA/B        : decode source indices
//   ReadDataA/B         : source operand values (combinational, bypassed)
//   DbgIndex / DbgData  : debug read, one-cycle latency, no bypass
//   WbCount             : count of committed register writes (wraps)
//   WbData              : selected write-back value for EX forwarding
// -----------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int NREG   = wb_regfile_pkg::NREG
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RegWrite3,
  input  logic              MemotoReg3,
  input  logic [DATA_W-1:0] DataOut3,
  input  logic [DATA_W-1:0] Result3,
  input  logic [IDX_W-1:0]  RegWriteIndex3,
  input  logic [IDX_W-1:0]  ReadIndexA,
  input  logic [IDX_W-1:0]  ReadIndexB,
  output logic [DATA_W-1:0] ReadDataA,
  output logic [DATA_W-1:0] ReadDataB,
  input  logic [IDX_W-1:0]  DbgIndex,
  output logic [DATA_W-1:0] DbgData,
  output logic [CNT_W-1:0]  WbCount,
  output logic [DATA_W-1:0] WbData
);

  logic [DATA_W-1:0] wb_data_s;
  logic [DATA_W-1:0] arr_a_s;
  logic [DATA_W-1:0] arr_b_s;
  logic [DATA_W-1:0] arr_d_s;
  logic              bypass_a_s;
  logic              bypass_b_s;
  logic [DATA_W-1:0] dbg_data_r;
  logic [CNT_W-1:0]  wb_count_r;

  // Write-back source mux; valid whether or not a write is enabled.
  always_comb begin
    if (MemotoReg3) begin
      wb_data_s = DataOut3;
    end else begin
      wb_data_s = Result3;
    end
  end

  regfile_array #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_array (
    .clk     (Clk),
    .rst     (Rst),
    .we      (RegWrite3),
    .waddr   (RegWriteIndex3),
    .wdata   (wb_data_s),
    .raddr_a (ReadIndexA),
    .raddr_b (ReadIndexB),
    .raddr_d (DbgIndex),
    .rdata_a (arr_a_s),
    .rdata_b (arr_b_s),
    .rdata_d (arr_d_s)
  );

  // Bypass compare per read port; suppressed during reset because the
  // pending write will be discarded at the edge.
  always_comb begin
    bypass_a_s = RegWrite3 && !Rst && (ReadIndexA == RegWriteIndex3);
    bypass_b_s = RegWrite3 && !Rst && (ReadIndexB == RegWriteIndex3);
  end

  // Operand read ports: bypassed write-back value or stored contents.
  always_comb begin
    if (bypass_a_s) begin
      ReadDataA = wb_data_s;
    end else begin
      ReadDataA = arr_a_s;
    end
    if (bypass_b_s) begin
      ReadDataB = wb_data_s;
    end else begin
      ReadDataB = arr_b_s;
    end
  end

  // Debug read register: captures pre-edge array contents (no bypass).
  always_ff @(posedge Clk) begin
    if (Rst) begin
      dbg_data_r <= '0;
    end else begin
      dbg_data_r <= arr_d_s;
    end
  end

  // Committed-write counter; wraps naturally at its full width.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wb_count_r <= '0;
    end else if (RegWrite3) begin
      wb_count_r <= wb_count_r + 16'd1;
    end else begin
      wb_count_r <= wb_count_r;
    end
  end

  assign WbData  = wb_data_s;
  assign DbgData = dbg_data_r;
  assign WbCount = wb_count_r;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Directed self-checking bench for wb_regfile. Inputs change 1 time unit
// after the rising edge; outputs are checked mid-cycle.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        RegWrite3;
  logic        MemotoReg3;
  logic [15:0] DataOut3;
  logic [15:0] Result3;
  logic [3:0]  RegWriteIndex3;
  logic [3:0]  ReadIndexA;
  logic [3:0]  ReadIndexB;
  logic [15:0] ReadDataA;
  logic [15:0] ReadDataB;
  logic [3:0]  DbgIndex;
  logic [15:0] DbgData;
  logic [15:0] WbCount;
  logic [15:0] WbData;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  wb_regfile dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .RegWrite3      (RegWrite3),
    .MemotoReg3     (MemotoReg3),
    .DataOut3       (DataOut3),
    .Result3        (Result3),
    .RegWriteIndex3 (RegWriteIndex3),
    .ReadIndexA     (ReadIndexA),
    .ReadIndexB     (ReadIndexB),
    .ReadDataA      (ReadDataA),
    .ReadDataB      (ReadDataB),
    .DbgIndex       (DbgIndex),
    .DbgData        (DbgData),
    .WbCount        (WbCount),
    .WbData         (WbData)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b1; RegWrite3 = 1'b0; MemotoReg3 = 1'b0;
    DataOut3 = 16'h0000; Result3 = 16'h0000; RegWriteIndex3 = 4'd0;
    ReadIndexA = 4'd0; ReadIndexB = 4'd0; DbgIndex = 4'd0;
    tick(); tick();
    Rst = 1'b0;
    #4;

    // Reset state: every register reads zero on both ports.
    for (int i = 0; i < 16; i++) begin
      ReadIndexA = 4'(i);
      ReadIndexB = 4'(15 - i);
      #1;
      chk("reset_rd_a", ReadDataA, 16'h0000);
      chk("reset_rd_b", ReadDataB, 16'h0000);
    end
    chk("reset_cnt", WbCount, 16'h0000);
    chk("reset_dbg", DbgData, 16'h0000);
    tick();

    // ALU result write to r5, bypassed on both ports in the same cycle.
    RegWrite3 = 1'b1; MemotoReg3 = 1'b0; Result3 = 16'h1234; DataOut3 = 16'h9999;
    RegWriteIndex3 = 4'd5; ReadIndexA = 4'd5; ReadIndexB = 4'd5; DbgIndex = 4'd5;
    #3;
    chk("byp_a_r5", ReadDataA, 16'h1234);
    chk("byp_b_r5", ReadDataB, 16'h1234);
    chk("wbdata_alu", WbData, 16'h1234);
    tick();
    chk("dbg_no_byp", DbgData, 16'h0000);
    chk("cnt_1", WbCount, 16'h0001);
    RegWrite3 = 1'b0;
    #3;
    chk("stored_r5", ReadDataA, 16'h1234);
    tick();
    chk("dbg_r5", DbgData, 16'h1234);

    // Load data write to r15; WbData follows the source select.
    RegWrite3 = 1'b1; MemotoReg3 = 1'b1; DataOut3 = 16'hBEEF; Result3 = 16'h0001;
    RegWriteIndex3 = 4'd15; ReadIndexA = 4'd15; ReadIndexB = 4'd5;
    #3;
    chk("wbdata_mem", WbData, 16'hBEEF);
    chk("byp_a_r15", ReadDataA, 16'hBEEF);
    chk("nobyp_b_r5", ReadDataB, 16'h1234);
    tick();
    RegWrite3 = 1'b0;
    #3;
    chk("stored_r15", ReadDataA, 16'hBEEF);
    chk("wbdata_mem_nowe", WbData, 16'hBEEF);
    MemotoReg3 = 1'b0;
    #1;
    chk("wbdata_alu_nowe", WbData, 16'h0001);
    chk("cnt_2", WbCount, 16'h0002);
    tick();

    // Disabled write to r3: no change, no bypass, counter holds.
    RegWrite3 = 1'b0; MemotoReg3 = 1'b0; Result3 = 16'hFFFF;
    RegWriteIndex3 = 4'd3; ReadIndexA = 4'd3; ReadIndexB = 4'd3;
    #3;
    chk("nowe_a_r3", ReadDataA, 16'h0000);
    chk("nowe_b_r3", ReadDataB, 16'h0000);
    tick();
    chk("after_nowe_r3", ReadDataA, 16'h0000);
    chk("cnt_still_2", WbCount, 16'h0002);

    // r0 is an ordinary register.
    RegWrite3 = 1'b1; Result3 = 16'hA5A5; RegWriteIndex3 = 4'd0;
    ReadIndexA = 4'd1; ReadIndexB = 4'd15;
    tick();
    RegWrite3 = 1'b0; ReadIndexA = 4'd0; ReadIndexB = 4'd5;
    #3;
    chk("stored_r0", ReadDataA, 16'hA5A5);
    chk("r5_kept", ReadDataB, 16'h1234);
    chk("cnt_3", WbCount, 16'h0003);
    tick();

    // Independent bypass: A hits the write, B reads another register.
    RegWrite3 = 1'b1; Result3 = 16'h7777; RegWriteIndex3 = 4'd5;
    ReadIndexA = 4'd5; ReadIndexB = 4'd15;
    #3;
    chk("indep_byp_a", ReadDataA, 16'h7777);
    chk("indep_nobyp_b", ReadDataB, 16'hBEEF);
    tick();

    // Reset with a coincident write: bypass suppressed, write discarded.
    Rst = 1'b1; RegWrite3 = 1'b1; MemotoReg3 = 1'b0; Result3 = 16'h5555;
    RegWriteIndex3 = 4'd7; ReadIndexA = 4'd7; ReadIndexB = 4'd5; DbgIndex = 4'd5;
    #3;
    chk("rst_nobyp_a", ReadDataA, 16'h0000);
    chk("rst_stored_b", ReadDataB, 16'h7777);
    tick();
    Rst = 1'b0; RegWrite3 = 1'b0;
    #3;
    chk("rst_r7", ReadDataA, 16'h0000);
    chk("rst_r5", ReadDataB, 16'h0000);
    chk("rst_cnt", WbCount, 16'h0000);
    chk("rst_dbg", DbgData, 16'h0000);
    tick();

    // Counter wrap: 65535 writes reach FFFF, the next one wraps to 0.
    RegWrite3 = 1'b1; Result3 = 16'h0F0F; RegWriteIndex3 = 4'd9;
    ReadIndexA = 4'd9; ReadIndexB = 4'd0;
    repeat (65535) @(posedge Clk);
    #1;
    chk("cnt_ffff", WbCount, 16'hFFFF);
    tick();
    chk("cnt_wrap", WbCount, 16'h0000);
    RegWrite3 = 1'b0;
    #3;
    chk("stored_r9", ReadDataA, 16'h0F0F);
    chk("r0_after_rst", ReadDataB, 16'h0000);
    tick();
    chk("cnt_hold_0", WbCount, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_regfile

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and data width.
REQ-002 SHALL have parameter NREG, default 16, number of architectural registers; index width is log2(NREG) = 4.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on posedge Clk.
REQ-004 SHALL have port Rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port RegWrite3, input, 1, write-back enable from the MEM/WB stage register.
REQ-006 SHALL have port MemotoReg3, input, 1, write-back source select: 1 selects DataOut3, 0 selects Result3.
REQ-007 SHALL have port DataOut3, input, DATA_W, memory load data.
REQ-008 SHALL have port Result3, input, DATA_W, ALU result.
REQ-009 SHALL have port RegWriteIndex3, input, 4, destination register index.
REQ-010 SHALL have ports ReadIndexA and ReadIndexB, input, 4 each, decode-stage source indices.
REQ-011 SHALL have ports ReadDataA and ReadDataB, output, DATA_W each, source operand values.
REQ-012 SHALL have port DbgIndex, input, 4, debug read index.
REQ-013 SHALL have port DbgData, output, DATA_W, registered debug read value.
REQ-014 SHALL have port WbCount, output, 16, count of committed register writes.
REQ-015 SHALL have port WbData, output, DATA_W, the selected write-back value, combinational, for forwarding to EX.

Function
REQ-016 WbData SHALL equal DataOut3 when MemotoReg3=1, else Result3, regardless of RegWrite3.
REQ-017 On posedge Clk with Rst=0 and RegWrite3=1, register[RegWriteIndex3] SHALL take WbData; no other register changes.
REQ-018 With RegWrite3=0, no register SHALL change.
REQ-019 ReadDataA and ReadDataB SHALL be combinational reads of the register array.
REQ-020 Bypass: if RegWrite3=1 and ReadIndexX equals RegWriteIndex3, ReadDataX SHALL equal WbData in the same cycle, so decode sees the value written at the next edge.
REQ-021 Both read ports SHALL bypass independently; identical A/B indices SHALL return identical data.
REQ-022 DbgData SHALL update each posedge to register[DbgIndex] as of before that edge's write, with one-cycle latency and no bypass.
REQ-023 WbCount SHALL increment by 1 on each edge with RegWrite3=1 and Rst=0, and SHALL wrap from 16'hFFFF to 0.
REQ-024 All index values 0..15 SHALL be writable; no register is hardwired.

Reset
REQ-025 While Rst=1 at posedge Clk, all registers, DbgData and WbCount SHALL become 0; a write presented in the same cycle SHALL be discarded.
REQ-026 While Rst=1, the bypass of REQ-020 SHALL be suppressed and ReadDataA/B SHALL reflect stored array contents.
REQ-027 A reset asserted mid-sequence SHALL take effect on the next edge with no partial writes retained.

Structure
REQ-028 DATA_W, NREG and the 4-bit index width SHALL be constants in the shared CPU package, also used by the pipeline stage registers.
REQ-029 The write-source mux and the bypass compare SHALL be in this module; no sub-module is required. The register array MAY be a sub-module regfile_array with one write port and three read ports.

Verification
REQ-030 Reset, then read all 16 indices on A and B -> all return 0; WbCount=0.
REQ-031 RegWrite3=1, MemotoReg3=0, Result3=16'h1234, index 5, ReadIndexA=5 in same cycle -> ReadDataA=16'h1234 before the edge; after the edge, DbgIndex=5 gives DbgData=16'h1234 one cycle later.
REQ-032 RegWrite3=1, MemotoReg3=1, DataOut3=16'hBEEF, Result3=16'h0001, index 15 -> register 15 = 16'hBEEF; WbData=16'hBEEF.
REQ-033 RegWrite3=0, index 3, Result3=16'hFFFF -> register 3 unchanged; no bypass on A=B=3; WbCount unchanged.
REQ-034 Rst=1 with RegWrite3=1, index 7, Result3=16'h5555 -> register 7 = 0 after the edge; WbCount=0.
REQ-035 Preload WbCount to 16'hFFFF by 65535 writes, then one more write -> WbCount=0.
